signed_mult_ctrl: RTL
=====================

SIGNED_MULT_CTRL -- requirements
Module: signed_mult_ctrl

Interface
REQ-001 Parameter MP_BITS, default 16, SHALL set the multiplier operand width in bits; legal range is 2..64.
REQ-002 Localparam CNT_W, equal to $clog2(MP_BITS), SHALL set the step counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 START  input  1  SHALL request a multiply and SHALL be sampled only in IDLE.
REQ-006 Q0  input  1  SHALL carry the datapath multiplier register LSB.
REQ-007 QM1  input  1  SHALL carry the datapath Booth extension bit Q(-1).
REQ-008 LOAD  output  1  SHALL load the operands and clear the accumulator and Q(-1).
REQ-009 ADD  output  1  SHALL command accumulator += multiplicand.
REQ-010 SUB  output  1  SHALL command accumulator -= multiplicand.
REQ-011 SHIFT  output  1  SHALL command an arithmetic right shift of {A,Q,Q(-1)}.
REQ-012 BUSY  output  1  SHALL be high in every state except IDLE.
REQ-013 DONE  output  1  SHALL be a one-cycle pulse marking the product as valid.
REQ-014 STEP  output  CNT_W  SHALL expose the completed-iteration count.

Function
REQ-015 The FSM states SHALL be IDLE, LOAD, EVAL, SHIFT and DONE.
REQ-016 IDLE SHALL go to LOAD on START=1; otherwise it SHALL stay in IDLE.
REQ-017 LOAD SHALL assert LOAD for exactly one cycle, clear STEP to 0 and go to EVAL.
REQ-018 EVAL SHALL decode {Q0,QM1}: 01 asserts ADD, 10 asserts SUB, 00 or 11 asserts neither; it then goes to SHIFT.
REQ-019 SHIFT SHALL assert SHIFT and increment STEP; it SHALL go to DONE when STEP==MP_BITS-1, else to EVAL.
REQ-020 DONE SHALL assert DONE for one cycle and return to IDLE.
REQ-021 ADD and SUB SHALL never be high together; LOAD, ADD/SUB and SHIFT SHALL be mutually exclusive.
REQ-022 LOAD, BUSY and DONE SHALL be decoded from state only; ADD, SUB and SHIFT MAY depend on Q0/QM1.
REQ-023 With START sampled at edge 0, LOAD SHALL be high in cycle 1 and DONE in cycle 2*MP_BITS+2 (cycle 34 for MP_BITS=16).
REQ-024 START SHALL be ignored while BUSY=1, including the DONE cycle; a new request SHALL need START high in IDLE.
REQ-025 STEP SHALL wrap from MP_BITS-1 to 0 only via LOAD, never by overflow.

Reset
REQ-026 rst=1 SHALL force state to IDLE and STEP to 0, and drive LOAD, ADD, SUB, SHIFT, BUSY and DONE to 0 from the following edge.
REQ-027 rst SHALL take priority over START and over any in-flight operation; an aborted multiply SHALL NOT produce a DONE pulse.

Configuration
REQ-028 Macro BOOTH_SKIP_EN, when defined, SHALL make EVAL with {Q0,QM1} equal to 00 or 11 assert SHIFT and increment STEP in the same cycle, then go to DONE (if STEP==MP_BITS-1) or stay in EVAL, bypassing SHIFT.
REQ-029 With BOOTH_SKIP_EN undefined, every iteration SHALL take exactly two cycles (EVAL then SHIFT), giving fixed latency.

Structure
REQ-030 Package signed_mult_pkg SHALL hold the state enum typedef and the MP_BITS default constant.
REQ-031 The step counter SHALL be sub-module mult_step_counter, with inputs clk, rst, clr and en, and outputs count and terminal flag (count==MP_BITS-1).

Verification
REQ-032 MP_BITS=16, START pulse, Q0/QM1 driven by a datapath model for 7 x -3 -> DONE in cycle 34, product -21, one DONE pulse.
REQ-033 Booth pair sequence 01,10,00,11 -> ADD, SUB, none, none in the successive EVAL cycles, with SHIFT in each following cycle.
REQ-034 START held high across a full operation -> exactly one LOAD per IDLE entry, and no re-trigger during BUSY or DONE.
REQ-035 rst asserted at STEP=5 -> IDLE, STEP=0 and all outputs 0 on the next edge, and no DONE pulse.
REQ-036 BOOTH_SKIP_EN defined, multiplier 0 -> DONE in cycle 18 (MP_BITS=16) and ADD/SUB never asserted.
REQ-037 MP_BITS=2, -2 x -2 -> DONE in cycle 6, product 4.

Source files
------------

// File: rtl/signed_mult_pkg.sv
// signed_mult_pkg: FSM encoding and default operand width shared by the Booth multiplier controller.
package signed_mult_pkg;

    localparam int MP_BITS_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EVAL  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/signed_mult_ctrl_step.sv
// mult_step_counter: Booth iteration counter; clears on LOAD, holds at MP_BITS-1 rather than wrapping.
module mult_step_counter
    import signed_mult_pkg::*;
#(
    parameter  int MP_BITS = MP_BITS_DEF,
    localparam int CNT_W   = $clog2(MP_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    assign term = count == CNT_W'(MP_BITS - 1);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && !term)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/signed_mult_ctrl.sv
// signed_mult_ctrl: radix-2 Booth multiplier sequencer driving LOAD/ADD/SUB/SHIFT to an external datapath.
// Build option BOOTH_SKIP_EN folds no-op Booth pairs (00/11) into a single shifting EVAL cycle.
module signed_mult_ctrl
    import signed_mult_pkg::*;
#(
    parameter  int MP_BITS = MP_BITS_DEF,
    localparam int CNT_W   = $clog2(MP_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             START,
    input  logic             Q0,
    input  logic             QM1,
    output logic             LOAD,
    output logic             ADD,
    output logic             SUB,
    output logic             SHIFT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] STEP
);

    state_t r_state;
    state_t w_next;
    logic   w_eval;
    logic   w_skip;
    logic   w_term;

    assign w_eval = r_state == S_EVAL;

`ifdef BOOTH_SKIP_EN
    assign w_skip = w_eval && (Q0 == QM1);
`else
    assign w_skip = 1'b0;
`endif

    // Unused encodings fall back to IDLE.
    always_comb begin
        w_next = (r_state == S_IDLE)  ? (START ? S_LOAD : S_IDLE) :
                 (r_state == S_LOAD)  ? S_EVAL :
                 (r_state == S_EVAL)  ? (w_skip ? (w_term ? S_DONE : S_EVAL) : S_SHIFT) :
                 (r_state == S_SHIFT) ? (w_term ? S_DONE : S_EVAL) :
                 S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    assign LOAD  = r_state == S_LOAD;
    assign BUSY  = r_state != S_IDLE;
    assign DONE  = r_state == S_DONE;
    assign ADD   = w_eval && !Q0 && QM1;
    assign SUB   = w_eval && Q0 && !QM1;
    assign SHIFT = (r_state == S_SHIFT) || w_skip;

    mult_step_counter #(
        .MP_BITS (MP_BITS)
    ) u_step (
        .clk   (clk),
        .rst   (rst),
        .clr   (LOAD),
        .en    (SHIFT),
        .count (STEP),
        .term  (w_term)
    );

endmodule
